// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/mult_addsub.sv
// N-bit adder/subtractor used for the multiplier accumulator update.
module mult_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s
);

  // two's-complement subtract: invert y and inject the carry
  assign s = x + (y ^ {N{sub}}) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Define MULT_SIGNED_EN to add the sgn port and signed operands.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_nx;
  logic [WIDTH:0]   mext;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic             accept;
  logic             last;
  logic             sub;
  logic             sgn_q;
  logic             fill;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == CW'(1));

`ifdef MULT_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q <= 1'b0;
    end else if (accept) begin
      sgn_q <= sgn;
    end
  end

  // signed mode weights the multiplier MSB negatively
  assign sub = sgn_q && last;
`else
  assign sgn_q = 1'b0;
  assign sub   = 1'b0;
`endif

  assign mext   = {sgn_q & mcand[WIDTH-1], mcand};
  assign addend = mplr[0] ? mext : '0;

  mult_addsub #(
    .N(WIDTH + 1)
  ) u_addsub (
    .x  (acc[2*WIDTH:WIDTH]),
    .y  (addend),
    .sub(sub),
    .s  (sum)
  );

  // unsigned carry lands in the shifted-in MSB; signed shifts arithmetically
  assign fill   = sgn_q & sum[WIDTH];
  assign acc_nx = {fill, sum, acc[WIDTH-1:1]};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mcand <= a;
        mplr  <= b;
        acc   <= '0;
        cnt   <= CW'(WIDTH);
      end else if (state == BUSY) begin
        acc   <= acc_nx;
        mplr  <= mplr >> 1;
        cnt   <= cnt - CW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=8).
// Signed vectors are exercised when MULT_SIGNED_EN is defined.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int n_chk;
  int n_pass;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             s;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[$];

  shift_add_multiplier #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
`ifdef MULT_SIGNED_EN
    .sgn      (sgn),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // plain integer multiply of the operands as the mode interprets them
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input bit s);
    longint xi;
    longint yi;
    longint pr;
    xi = longint'(x);
    yi = longint'(y);
    if (s && x[W-1]) xi = xi - (longint'(1) << W);
    if (s && y[W-1]) yi = yi - (longint'(1) << W);
    pr = xi * yi;
    return pr[2*W-1:0];
  endfunction

  // one full transaction; lat counts edges from and including the accept edge
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit ts, output logic [2*W-1:0] tp,
                       output int lat, output int bcnt);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", longint'(in_ready), 1);
    a = ta; b = tb; sgn = ts;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 50) begin
      bcnt += int'(busy);
      a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    bcnt += int'(busy);
    tp = p;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2*W-1:0] rp;
    int             lat;
    int             bcnt;
    int             acc_t[$];
    logic [2*W-1:0] expq[$];
    logic [2*W-1:0] gotq[$];
    logic [W-1:0]   ops_a[3];
    logic [W-1:0]   ops_b[3];
    int             k;
    int             cyc;
    bit             acc_now;
    bit             s;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] held;

    n_chk = 0; n_pass = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sgn = 1'b0;

    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
    vecs.push_back('{8'h00, 8'hA5, 1'b0, 16'h0000});
    vecs.push_back('{8'hA5, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{8'h03, 8'h07, 1'b0, 16'h0015});
    vecs.push_back('{8'h01, 8'h01, 1'b0, 16'h0001});
    vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
    vecs.push_back('{8'hFF, 8'h05, 1'b1, 16'hFFFB});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_p", longint'(p), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, rp, lat, bcnt);
      chk($sformatf("vec%0d_p", i), longint'(rp), longint'(vecs[i].p));
      chk($sformatf("vec%0d_lat", i), lat, W + 1);
      chk($sformatf("vec%0d_busy", i), bcnt, W + 1);
    end

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
`ifdef MULT_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      do_op(ra, rb, s, rp, lat, bcnt);
      chk($sformatf("rnd%0d_p", i), longint'(rp), longint'(ref_mul(ra, rb, s)));
    end

    // backpressure: hold DONE, poke in_valid, then release
    a = 8'h0F; b = 8'h11; sgn = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("bp_valid", longint'(out_valid), 1);
    held = p;
    chk("bp_p", longint'(held), 16'h00FF);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_p", i), longint'(p), longint'(held));
      chk($sformatf("bp_hold%0d_rdy", i), longint'(in_ready), 0);
      chk($sformatf("bp_hold%0d_vld", i), longint'(out_valid), 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_rdy", longint'(in_ready), 1);
    chk("bp_idle_vld", longint'(out_valid), 0);

    // reset in the middle of an operation
    a = 8'hFF; b = 8'hFF; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", longint'(busy), 1);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_rdy", longint'(in_ready), 1);
    chk("mid_rst_vld", longint'(out_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_p", longint'(p), 0);
    @(posedge clk); #1;
    chk("rst_cycle_ignored", longint'(busy), 0);
    do_op(8'd3, 8'd7, 1'b0, rp, lat, bcnt);
    chk("post_rst_p", longint'(rp), 16'h0015);

    // back-to-back with in_valid held high
    ops_a[0] = 8'hC3; ops_b[0] = 8'h5A;
    ops_a[1] = 8'h00; ops_b[1] = 8'hFF;
    ops_a[2] = 8'hFE; ops_b[2] = 8'h02;
    k = 0; cyc = 0;
    a = ops_a[0]; b = ops_b[0]; sgn = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (gotq.size() < 3 && cyc < 100) begin
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        acc_t.push_back(cyc);
        expq.push_back(ref_mul(a, b, 1'b0));
      end
      if (out_valid) gotq.push_back(p);
      @(posedge clk); #1; cyc++;
      if (acc_now) begin
        k++;
        if (k < 3) begin
          a = ops_a[k]; b = ops_b[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc_t.size(), 3);
    chk("b2b_results", gotq.size(), 3);
    for (int i = 1; i < acc_t.size(); i++)
      chk($sformatf("b2b_gap%0d", i), acc_t[i] - acc_t[i-1], W + 2);
    for (int i = 0; i < gotq.size() && i < expq.size(); i++)
      chk($sformatf("b2b_p%0d", i), longint'(gotq[i]), longint'(expq[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 in_valid  input  1  operands a/b (and sgn) valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 sgn  input  1  1 = two's-complement operands, 0 = unsigned; present only with MULT_SIGNED_EN.
REQ-009 out_valid  output  1  product p valid.
REQ-010 out_ready  input  1  consumer takes p.
REQ-011 p  output  2*WIDTH  product.
REQ-012 busy  output  1  high while state is not IDLE.

Function
REQ-013 FSM SHALL have states IDLE, BUSY, DONE; in_ready SHALL equal (state==IDLE).
REQ-014 IDLE->BUSY when in_valid&&in_ready; a, b, sgn SHALL be captured that edge, accumulator cleared, iteration counter loaded with WIDTH.
REQ-015 BUSY SHALL process one multiplier bit per cycle, LSB first: if bit set, add multiplicand into upper WIDTH+1 accumulator bits, then shift accumulator right one.
REQ-016 Counter SHALL decrement each BUSY cycle; BUSY->DONE on the cycle it reaches 0, i.e. exactly WIDTH BUSY cycles.
REQ-017 out_valid SHALL assert exactly WIDTH+1 rising edges after the accepting edge and equal (state==DONE).
REQ-018 In DONE, p and out_valid SHALL hold stable until out_valid&&out_ready; then DONE->IDLE on that edge.
REQ-019 No input accepted in BUSY or DONE; in_valid there SHALL be ignored; maximum throughput one product per WIDTH+2 cycles.
REQ-020 Unsigned result SHALL equal a*b exactly in 2*WIDTH bits; no overflow possible.
REQ-021 Operand value zero SHALL still take the full WIDTH BUSY cycles (fixed latency, no early exit).
REQ-022 Operand and p changes outside the accept edge SHALL not affect the computation.

Reset
REQ-023 rst SHALL force state IDLE, counter 0, accumulator 0 regardless of current state, including mid-BUSY and DONE.
REQ-024 During and after reset: in_ready=1, out_valid=0, busy=0, p=0; an in-flight product SHALL be discarded.
REQ-025 in_valid in the reset cycle SHALL not be accepted.

Configuration
REQ-026 Macro MULT_SIGNED_EN: when defined, sgn port exists; with sgn=1 accumulator add SHALL sign-extend multiplicand, and the final (MSB) iteration SHALL subtract instead of add, giving signed a*b in 2*WIDTH bits.
REQ-027 Without MULT_SIGNED_EN: no sgn port, unsigned-only behaviour, no subtract logic synthesised.

Structure
REQ-028 Package mult_pkg SHALL hold the state enum typedef (IDLE, BUSY, DONE) and default-WIDTH constant.
REQ-029 Counter width SHALL be $clog2(WIDTH+1) bits, derived locally.
REQ-030 Sub-module mult_addsub (WIDTH+1-bit adder/subtractor, sub input) SHALL implement the accumulator update.

Verification (WIDTH=8)
REQ-031 Unsigned: a=0xFF, b=0xFF -> out_valid 9 edges after accept, p=0xFE01.
REQ-032 Zero: a=0x00, b=0xA5 -> p=0x0000, same 9-edge latency, busy high 9 cycles.
REQ-033 Signed (MULT_SIGNED_EN, sgn=1): a=0x80, b=0x80 -> p=0x4000; a=0xFF, b=0x05 -> p=0xFFFB.
REQ-034 Backpressure: out_ready=0 for 5 cycles after out_valid -> p stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-035 Reset mid-op: rst at BUSY cycle 4 -> next cycle in_ready=1, out_valid=0, p=0; new a=3, b=7 -> p=0x0015.
REQ-036 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced 10 cycles apart, results in order.
